microseq: RTL and testbench
===========================

# microseq

Microprogram sequencer for the microcoded CPU. It replaces combinational next-state selection with a registered micro-program counter (µPC) that drives the control store address. It adds conditional branching on any selected condition code, a bounded micro-subroutine stack (CALL/RET) and a hold input so the execution unit or main memory can stall sequencing. It sits between the instruction decoder, the execution unit condition codes and the control store.

## Interface

Parameters:
- AW, 5, control store address width (bits of µPC, ib, sb, db).
- DEPTH, 4, micro-subroutine stack entries (power of two, ≥2).
- RESET_ADDR, 0, µPC value after reset and after stack underflow.

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high; sampled on rising edge of clock.
- ib  input  AW  instruction dispatch address from the instruction decoder.
- sb  input  AW  secondary (source) dispatch address from the instruction decoder.
- db  input  AW  direct branch field of the current control word.
- cc  input  4  condition codes {Z,N,C,V}, bit 3 = Z, bit 0 = V.
- seqop  input  3  sequencing operation for this cycle (encoding below).
- ccsel  input  2  condition select: 0=V, 1=C, 2=N, 3=Z (index into cc).
- hold  input  1  stall: freeze µPC and stack this cycle.
- nextst  output  AW  registered µPC, wired to the control store address.
- sp  output  log2(DEPTH)+1  number of valid stack entries (0..DEPTH).
- stkerr  output  1  sticky stack overflow/underflow flag.

## Operation

- Let inc = (nextst + 1) mod 2^AW, so the maximum address wraps to 0. Let cond = cc[ccsel].
- seqop encoding, giving the µPC loaded at the edge:
  - 000 CONT: inc.
  - 001 JMP: db.
  - 010 DISP: ib.
  - 011 SDISP: sb.
  - 100 BRT: cond ? db : inc.
  - 101 BRF: cond ? inc : db.
  - 110 CALL: push inc; load db.
  - 111 RET: pop top entry into µPC.
- Stack is LIFO of AW-bit entries. sp counts entries. Push writes entry[sp] and sets sp+1. Pop reads entry[sp-1] and sets sp-1.
- Overflow: CALL with sp==DEPTH.
  - No push; sp and entries unchanged.
  - µPC still loads db.
  - stkerr <= 1.
- Underflow: RET with sp==0.
  - µPC loads RESET_ADDR; sp stays 0.
  - stkerr <= 1.
- stkerr is sticky and clears only on reset.
- Priority per edge: reset > hold > seqop.
  - hold=1: µPC, sp, entries and stkerr all unchanged, whatever seqop is. A CALL or RET during hold has no side effect.
  - The same seqop must be re-presented when hold drops. Inputs are expected stable during hold, since the control word is held by the same address.
- Entries above sp are don't-care. They are not cleared on pop or reset.
- No other state. The block has no combinational path from inputs to outputs.

## Timing

- Reset: the edge with reset=1 sets nextst=RESET_ADDR, sp=0, stkerr=0. This holds for all seqop/hold values and mid-subroutine (pending returns discarded).
- Latency: seqop/db/ib/sb/cc/ccsel/hold sampled at edge k; nextst, sp, stkerr valid after edge k. This is one cycle, with no bypass.
- cc is sampled at the same edge as seqop. The execution unit must present flags from the previous operation by then.
- One sequencing operation per unheld cycle. The throughput is one µPC update per clock.
- A CALL followed immediately by RET in consecutive unheld cycles returns to the CALL's inc. This is legal with no bubble.
- hold may be asserted for any number of cycles. Deasserting it resumes on the next edge.

## Test plan

- Reset/CONT wrap:
  - Stimulus: reset one edge, then CONT ×33 with AW=5.
  - Required: nextst=0 after reset, then 1,2,…,31,0,1; sp=0; stkerr=0.
- Dispatch and branch:
  - Stimulus: at nextst=3, DISP with ib=12.
  - Required: 12.
  - Stimulus: BRT ccsel=3 with cc=4'b1000 and db=20.
  - Required: 20.
  - Stimulus: BRF with the same cc.
  - Required: 21.
  - Stimulus: SDISP sb=7.
  - Required: 7.
- Nested CALL/RET:
  - Stimulus: at nextst=2, CALL db=10; at 10, CALL db=16; RET; RET.
  - Required: nextst sequence 10,16,11,3; sp sequence 1,2,1,0; stkerr=0.
- Overflow/underflow with DEPTH=4:
  - Stimulus: 5 successive CALLs.
  - Required: sp saturates at 4, stkerr=1 after the 5th, µPC=db of the 5th.
  - Stimulus: 4 RETs.
  - Required: the first 4 pushed return addresses come back in reverse order.
  - Stimulus: a 5th RET.
  - Required: nextst=0 and stkerr remains 1.
- Hold:
  - Stimulus: at nextst=5, hold=1 for 3 cycles with seqop=CALL db=9.
  - Required: nextst=5 and sp=0 throughout.
  - Stimulus: release hold.
  - Required: nextst=9, sp=1, top entry=6.
- Reset mid-subroutine:
  - Stimulus: with sp=2 and stkerr=1, assert reset together with hold=1 and seqop=RET.
  - Required: nextst=0, sp=0, stkerr=0 after that edge.
  - Stimulus: a subsequent RET.
  - Required: underflow, stkerr=1.

Source files
------------

// File: rtl/microseq.sv
// Microprogram sequencer: registered micro-PC with conditional branching,
// dispatch, and a bounded micro-subroutine stack with sticky error flag.
module microseq #(
  parameter int AW = 5,
  parameter int DEPTH = 4,
  parameter logic [AW-1:0] RESET_ADDR = '0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [AW-1:0]           ib,
  input  logic [AW-1:0]           sb,
  input  logic [AW-1:0]           db,
  input  logic [3:0]              cc,
  input  logic [2:0]              seqop,
  input  logic [1:0]              ccsel,
  input  logic                    hold,
  output logic [AW-1:0]           nextst,
  output logic [$clog2(DEPTH):0]  sp,
  output logic                    stkerr
);

  localparam int SPW = $clog2(DEPTH) + 1;
  localparam logic [SPW-1:0] FULL = SPW'(DEPTH);

  typedef enum logic [2:0] {
    OP_CONT  = 3'b000,
    OP_JMP   = 3'b001,
    OP_DISP  = 3'b010,
    OP_SDISP = 3'b011,
    OP_BRT   = 3'b100,
    OP_BRF   = 3'b101,
    OP_CALL  = 3'b110,
    OP_RET   = 3'b111
  } seqop_t;

  logic [AW-1:0]  stack [DEPTH];
  logic [AW-1:0]  inc;
  logic [AW-1:0]  pc_next;
  logic [SPW-2:0] top_idx;
  logic           cond;
  logic           push;
  logic           pop;
  logic           err_set;

  // Low bits of sp wrap to DEPTH-1 when sp==DEPTH, so top_idx is always the top entry.
  always_comb begin
    inc     = nextst + AW'(1);
    cond    = cc[ccsel];
    top_idx = sp[SPW-2:0] - (SPW-1)'(1);
    pc_next = inc;
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
    case (seqop_t'(seqop))
      OP_CONT:  pc_next = inc;
      OP_JMP:   pc_next = db;
      OP_DISP:  pc_next = ib;
      OP_SDISP: pc_next = sb;
      OP_BRT:   pc_next = cond ? db : inc;
      OP_BRF:   pc_next = cond ? inc : db;
      OP_CALL: begin
        pc_next = db;
        if (sp == FULL) err_set = 1'b1;
        else            push    = 1'b1;
      end
      OP_RET: begin
        if (sp == '0) begin
          pc_next = RESET_ADDR;
          err_set = 1'b1;
        end else begin
          pc_next = stack[top_idx];
          pop     = 1'b1;
        end
      end
      default: pc_next = inc;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      nextst <= RESET_ADDR;
      sp     <= '0;
      stkerr <= 1'b0;
    end else if (!hold) begin
      nextst <= pc_next;
      if (push)     sp <= sp + SPW'(1);
      else if (pop) sp <= sp - SPW'(1);
      if (err_set) stkerr <= 1'b1;
    end
  end

  // Entries are never cleared; only the slots below sp are meaningful.
  always_ff @(posedge clock) begin
    if (!reset && !hold && push) stack[sp[SPW-2:0]] <= inc;
  end

endmodule

// File: tb/tb_microseq.sv
// Self-checking bench for microseq: directed vector table from the test plan,
// then randomized traffic checked against a queue-based reference model.
module tb_microseq;

  localparam int AW = 5;
  localparam int DEPTH = 4;
  localparam int SPW = $clog2(DEPTH) + 1;

  localparam logic [2:0] CONT  = 3'd0;
  localparam logic [2:0] JMP   = 3'd1;
  localparam logic [2:0] DISP  = 3'd2;
  localparam logic [2:0] SDISP = 3'd3;
  localparam logic [2:0] BRT   = 3'd4;
  localparam logic [2:0] BRF   = 3'd5;
  localparam logic [2:0] CALL  = 3'd6;
  localparam logic [2:0] RET   = 3'd7;

  logic           clock = 1'b0;
  logic           reset;
  logic [AW-1:0]  ib, sb, db;
  logic [3:0]     cc;
  logic [2:0]     seqop;
  logic [1:0]     ccsel;
  logic           hold;
  logic [AW-1:0]  nextst;
  logic [SPW-1:0] sp;
  logic           stkerr;

  microseq #(.AW(AW), .DEPTH(DEPTH), .RESET_ADDR('0)) dut (
    .clock(clock), .reset(reset), .ib(ib), .sb(sb), .db(db), .cc(cc),
    .seqop(seqop), .ccsel(ccsel), .hold(hold),
    .nextst(nextst), .sp(sp), .stkerr(stkerr)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic           rst;
    logic           hld;
    logic [2:0]     op;
    logic [AW-1:0]  ibv;
    logic [AW-1:0]  sbv;
    logic [AW-1:0]  dbv;
    logic [3:0]     ccv;
    logic [1:0]     sel;
    logic [AW-1:0]  e_pc;
    logic [SPW-1:0] e_sp;
    logic           e_err;
  } vec_t;

  vec_t vecs[$];
  int   vec_count = 0;
  int   miss_count = 0;

  // Reference model state
  int   m_pc;
  int   m_stk[$];
  bit   m_err;

  function automatic void addVec(logic rst, logic hld, logic [2:0] op,
                                 int ibv, int sbv, int dbv, logic [3:0] ccv,
                                 logic [1:0] sel, int e_pc, int e_sp, logic e_err);
    vec_t v;
    v.rst = rst; v.hld = hld; v.op = op;
    v.ibv = AW'(ibv); v.sbv = AW'(sbv); v.dbv = AW'(dbv);
    v.ccv = ccv; v.sel = sel;
    v.e_pc = AW'(e_pc); v.e_sp = SPW'(e_sp); v.e_err = e_err;
    vecs.push_back(v);
  endfunction

  // Plain addresses: short form for the common case with no condition codes involved
  function automatic void addOp(logic [2:0] op, int dbv, int e_pc, int e_sp, logic e_err);
    addVec(1'b0, 1'b0, op, 0, 0, dbv, 4'h0, 2'd0, e_pc, e_sp, e_err);
  endfunction

  task automatic applyStimulus(input vec_t v);
    reset = v.rst; hold = v.hld; seqop = v.op;
    ib = v.ibv; sb = v.sbv; db = v.dbv; cc = v.ccv; ccsel = v.sel;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [AW-1:0] e_pc,
                             input logic [SPW-1:0] e_sp, input logic e_err);
    vec_count++;
    if (nextst !== e_pc || sp !== e_sp || stkerr !== e_err) begin
      miss_count++;
      $display("[TB] FAIL %s: got nextst=%0d sp=%0d stkerr=%0d, expected nextst=%0d sp=%0d stkerr=%0d",
               name, nextst, sp, stkerr, e_pc, e_sp, e_err);
    end
  endtask

  // Reference model: one edge of sequencing, stated directly from the rules
  task automatic modelStep(input vec_t v);
    int inc;
    bit cnd;
    inc = (m_pc + 1) % (1 << AW);
    cnd = v.ccv[v.sel];
    if (v.rst) begin
      m_pc = 0; m_stk.delete(); m_err = 0;
    end else if (!v.hld) begin
      case (v.op)
        CONT:  m_pc = inc;
        JMP:   m_pc = int'(v.dbv);
        DISP:  m_pc = int'(v.ibv);
        SDISP: m_pc = int'(v.sbv);
        BRT:   m_pc = cnd ? int'(v.dbv) : inc;
        BRF:   m_pc = cnd ? inc : int'(v.dbv);
        CALL: begin
          if (m_stk.size() == DEPTH) m_err = 1;
          else m_stk.push_back(inc);
          m_pc = int'(v.dbv);
        end
        default: begin
          if (m_stk.size() == 0) begin
            m_pc = 0; m_err = 1;
          end else begin
            m_pc = m_stk.pop_back();
          end
        end
      endcase
    end
  endtask

  initial begin
    reset = 1'b1; hold = 1'b0; seqop = CONT;
    ib = '0; sb = '0; db = '0; cc = '0; ccsel = '0;

    // Reset then CONT wrap across the top of the address space
    addVec(1'b1, 1'b0, CONT, 0, 0, 0, 4'h0, 2'd0, 0, 0, 1'b0);
    for (int i = 1; i <= 33; i++) addOp(CONT, 0, i % 32, 0, 1'b0);

    // Dispatch and branch
    addOp(JMP, 3, 3, 0, 1'b0);
    addVec(1'b0, 1'b0, DISP,  12, 0, 0,  4'b0000, 2'd0, 12, 0, 1'b0);
    addVec(1'b0, 1'b0, BRT,   0,  0, 20, 4'b1000, 2'd3, 20, 0, 1'b0);
    addVec(1'b0, 1'b0, BRF,   0,  0, 20, 4'b1000, 2'd3, 21, 0, 1'b0);
    addVec(1'b0, 1'b0, SDISP, 0,  7, 0,  4'b0000, 2'd0, 7,  0, 1'b0);
    addVec(1'b0, 1'b0, BRT,   0,  0, 2,  4'b0111, 2'd3, 8,  0, 1'b0);
    addVec(1'b0, 1'b0, BRF,   0,  0, 2,  4'b0001, 2'd1, 2,  0, 1'b0);

    // Nested CALL/RET from address 2
    addOp(CALL, 10, 10, 1, 1'b0);
    addOp(CALL, 16, 16, 2, 1'b0);
    addOp(RET,  0,  11, 1, 1'b0);
    addOp(RET,  0,  3,  0, 1'b0);

    // Overflow on the fifth CALL, drain, then underflow
    addOp(CALL, 8,  8,  1, 1'b0);
    addOp(CALL, 12, 12, 2, 1'b0);
    addOp(CALL, 16, 16, 3, 1'b0);
    addOp(CALL, 20, 20, 4, 1'b0);
    addOp(CALL, 24, 24, 4, 1'b1);
    addOp(RET,  0,  17, 3, 1'b1);
    addOp(RET,  0,  13, 2, 1'b1);
    addOp(RET,  0,  9,  1, 1'b1);
    addOp(RET,  0,  4,  0, 1'b1);
    addOp(RET,  0,  0,  0, 1'b1);

    // Hold freezes a pending CALL; release lets it execute
    addVec(1'b1, 1'b0, CONT, 0, 0, 0, 4'h0, 2'd0, 0, 0, 1'b0);
    addOp(JMP, 5, 5, 0, 1'b0);
    for (int i = 0; i < 3; i++) addVec(1'b0, 1'b1, CALL, 0, 0, 9, 4'h0, 2'd0, 5, 0, 1'b0);
    addOp(CALL, 9, 9, 1, 1'b0);
    addOp(RET,  0, 6, 0, 1'b0);

    // Reset wins over hold and RET mid-subroutine
    addOp(RET,  0, 0, 0, 1'b1);
    addOp(CALL, 4, 4, 1, 1'b1);
    addOp(CALL, 7, 7, 2, 1'b1);
    addVec(1'b1, 1'b1, RET, 0, 0, 0, 4'h0, 2'd0, 0, 0, 1'b0);
    addOp(RET,  0, 0, 0, 1'b1);

    @(negedge clock);
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("directed%0d", i), vecs[i].e_pc, vecs[i].e_sp, vecs[i].e_err);
      @(negedge clock);
    end

    // Randomized traffic against the reference model
    begin
      vec_t v;
      v = '{rst: 1'b1, hld: 1'b0, op: CONT, ibv: '0, sbv: '0, dbv: '0,
            ccv: '0, sel: '0, e_pc: '0, e_sp: '0, e_err: 1'b0};
      modelStep(v);
      applyStimulus(v);
      checkOutput("rand_reset", AW'(m_pc), SPW'(m_stk.size()), m_err);
      @(negedge clock);
      for (int n = 0; n < 600; n++) begin
        v.rst = ($urandom_range(0, 99) < 3);
        v.hld = ($urandom_range(0, 99) < 20);
        v.op  = 3'($urandom_range(0, 7));
        v.ibv = AW'($urandom);
        v.sbv = AW'($urandom);
        v.dbv = AW'($urandom);
        v.ccv = 4'($urandom);
        v.sel = 2'($urandom);
        modelStep(v);
        applyStimulus(v);
        checkOutput($sformatf("random%0d", n), AW'(m_pc), SPW'(m_stk.size()), m_err);
        @(negedge clock);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
